nco_phase_inc_sweep: RTL

// - Upstream control stage for the NCO. Generates the phase increment word (phi_inc_o) that drives the NCO's phi_inc_i input.
// - Produces a stepped linear frequency sweep from f_start to f_stop: dwell, step, repeat.
// - Two modes: one-shot up-sweep, or continuous triangle (up/down).
// - Shares the NCO's clock, reset and clken, so sweep timing is counted in NCO samples.

---
 rtl/nco_phase_inc_sweep_pkg.sv | 15 +
 rtl/nco_phase_inc_sweep_dwell_cnt.sv | 31 +++
 rtl/nco_phase_inc_sweep.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nco_phase_inc_sweep_pkg.sv
// Shared definitions for the NCO phase-increment sweep generator:
// FSM state encodings and sweep-mode constants.
package nco_phase_inc_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_TRI     = 1'b1;

endpackage

// File: rtl/nco_phase_inc_sweep_dwell_cnt.sv
// Loadable dwell down-counter; tc flags a zero count so the sweep FSM knows
// when the current increment has been held long enough.
module nco_sweep_dwell_cnt #(
    parameter int DWELLW = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clken,
    input  logic              i_load,
    input  logic              i_dec,
    input  logic [DWELLW-1:0] i_load_val,
    output logic              o_tc
);

    logic [DWELLW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clken) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != '0)) begin
                r_count <= r_count - DWELLW'(1);
            end
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/nco_phase_inc_sweep.sv
// Stepped linear frequency sweep for the NCO phase increment: one-shot up
// or continuous triangle, clamped to [f_start, f_stop], timed in clken cycles.
module nco_phase_inc_sweep
    import nco_phase_inc_sweep_pkg::*;
#(
    parameter int APR    = 32,
    parameter int DWELLW = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [APR-1:0]    f_start,
    input  logic [APR-1:0]    f_stop,
    input  logic [APR-1:0]    f_step,
    input  logic [DWELLW-1:0] dwell,
    output logic [APR-1:0]    phi_inc_o,
    output logic              busy,
    output logic              step_stb,
    output logic              sweep_done
);

    state_t            r_state;
    state_t            w_state_next;
    logic [APR-1:0]    r_phi;
    logic [APR-1:0]    w_phi_next;
    logic [APR-1:0]    r_f_start;
    logic [APR-1:0]    r_f_stop;
    logic [APR-1:0]    r_f_step;
    logic [DWELLW-1:0] r_dwell_rl;
    logic              r_mode;
    logic              r_step_stb;
    logic              r_sweep_done;

    logic              w_step_next;
    logic              w_done_next;
    logic              w_latch;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_tc;
    logic              w_degen;
    logic [DWELLW-1:0] w_dwell_rl_in;
    logic [DWELLW-1:0] w_cnt_load_val;
    logic [APR:0]      w_sum;
    logic [APR:0]      w_diff;

    // Reload value is max(dwell,1)-1, so a dwell of 0 behaves like 1.
    assign w_dwell_rl_in  = (dwell == '0) ? '0 : dwell - DWELLW'(1);
    assign w_cnt_load_val = w_latch ? w_dwell_rl_in : r_dwell_rl;
    assign w_degen        = (f_step == '0) || (f_stop <= f_start);

    // One extra bit exposes carry/borrow so the value never wraps.
    assign w_sum  = {1'b0, r_phi} + {1'b0, r_f_step};
    assign w_diff = {1'b0, r_phi} - {1'b0, r_f_step};

    always_comb begin
        w_state_next = r_state;
        w_phi_next   = r_phi;
        w_step_next  = 1'b0;
        w_done_next  = 1'b0;
        w_latch      = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;

        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_latch    = 1'b1;
                        w_cnt_load = 1'b1;
                        w_phi_next = f_start;
                        if (w_degen) begin
                            w_state_next = ST_DONE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = ST_UP;
                        end
                    end
                end
                ST_UP: begin
                    if (w_tc) begin
                        w_step_next = 1'b1;
                        w_cnt_load  = 1'b1;
                        if (w_sum >= {1'b0, r_f_stop}) begin
                            w_phi_next = r_f_stop;
                            if (r_mode == MODE_TRI) begin
                                w_state_next = ST_DOWN;
                            end else begin
                                w_state_next = ST_DONE;
                                w_done_next  = 1'b1;
                            end
                        end else begin
                            w_phi_next = w_sum[APR-1:0];
                        end
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (w_tc) begin
                        w_step_next = 1'b1;
                        w_cnt_load  = 1'b1;
                        if (w_diff[APR] || (w_diff[APR-1:0] <= r_f_start)) begin
                            w_phi_next   = r_f_start;
                            w_state_next = ST_UP;
                        end else begin
                            w_phi_next = w_diff[APR-1:0];
                        end
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Pulses are registered and only cleared on a clken cycle, so they hold with clken low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_phi        <= '0;
            r_step_stb   <= 1'b0;
            r_sweep_done <= 1'b0;
            r_f_start    <= '0;
            r_f_stop     <= '0;
            r_f_step     <= '0;
            r_dwell_rl   <= '0;
            r_mode       <= MODE_ONESHOT;
        end else if (clken) begin
            r_state      <= w_state_next;
            r_phi        <= w_phi_next;
            r_step_stb   <= w_step_next;
            r_sweep_done <= w_done_next;
            if (w_latch) begin
                r_f_start  <= f_start;
                r_f_stop   <= f_stop;
                r_f_step   <= f_step;
                r_dwell_rl <= w_dwell_rl_in;
                r_mode     <= mode;
            end
        end
    end

    nco_sweep_dwell_cnt #(
        .DWELLW (DWELLW)
    ) u_dwell_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clken    (clken),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (w_cnt_load_val),
        .o_tc       (w_tc)
    );

    assign phi_inc_o  = r_phi;
    assign busy       = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign step_stb   = r_step_stb;
    assign sweep_done = r_sweep_done;

endmodule
